// File: rtl/rv_pipe_pkg.sv
// Shared opcodes, ALU operations and decoded control for the three-stage core.
// Decode is a pure function so the ID stage is a single combinational block.
package rv_pipe_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
   } alu_op_e;

   typedef struct packed {
      alu_op_e    op;
      logic       use_rs1;
      logic       use_rs2;
      logic       use_imm;
      logic       wr_en;
      logic       illegal;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ctl_t;

   function automatic ctl_t decode(input logic [31:0] ins,
                                   input int nreg,
                                   input int xlen);
      ctl_t       c;
      logic [6:0] f7;
      logic [2:0] f3;
      logic       ok;
      logic       sh_ok;
      f7    = ins[31:25];
      f3    = ins[14:12];
      c     = '0;
      c.rd  = ins[11:7];
      c.rs1 = ins[19:15];
      c.rs2 = ins[24:20];
      ok    = 1'b1;
      // shamt bit 5 lives in funct7[0] and is only legal on RV64
      sh_ok = (xlen == 64) || !f7[0];
      case (ins[6:0])
         OPC_OP: begin
            c.use_rs1 = 1'b1;
            c.use_rs2 = 1'b1;
            ok = (f7 == 7'h00) ||
                 (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            case (f3)
               3'b000: c.op = f7[5] ? ALU_SUB : ALU_ADD;
               3'b001: c.op = ALU_SLL;
               3'b010: c.op = ALU_SLT;
               3'b011: c.op = ALU_SLTU;
               3'b100: c.op = ALU_XOR;
               3'b101: c.op = f7[5] ? ALU_SRA : ALU_SRL;
               3'b110: c.op = ALU_OR;
               3'b111: c.op = ALU_AND;
            endcase
         end
         OPC_OP_IMM: begin
            c.use_rs1 = 1'b1;
            c.use_imm = 1'b1;
            case (f3)
               3'b000: c.op = ALU_ADD;
               3'b001: begin
                  c.op = ALU_SLL;
                  ok   = (f7[6:1] == 6'd0) && sh_ok;
               end
               3'b010: c.op = ALU_SLT;
               3'b011: c.op = ALU_SLTU;
               3'b100: c.op = ALU_XOR;
               3'b101: begin
                  c.op = f7[5] ? ALU_SRA : ALU_SRL;
                  ok   = !f7[6] && (f7[4:1] == 4'd0) && sh_ok;
               end
               3'b110: c.op = ALU_OR;
               3'b111: c.op = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            c.use_imm = 1'b1;
            c.op      = ALU_LUI;
         end
         default: ok = 1'b0;
      endcase
      if (int'(c.rd) >= nreg) ok = 1'b0;
      if (c.use_rs1 && int'(c.rs1) >= nreg) ok = 1'b0;
      if (c.use_rs2 && int'(c.rs2) >= nreg) ok = 1'b0;
      c.illegal = !ok;
      c.wr_en   = ok;
      if (!ok) begin
         c.use_rs1 = 1'b0;
         c.use_rs2 = 1'b0;
      end
      return c;
   endfunction

endpackage

// File: rtl/rv_pipe_regfile.sv
// Two-read one-write register file with write-through and x0 hardwired to 0.
// Out-of-range addresses read as zero and never write.
module rv_pipe_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ra1,
   output logic [XLEN-1:0] rd1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] rf [NREG];

   function automatic logic in_range(input logic [4:0] a);
      return int'(a) < NREG;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (we && wa != 5'd0 && in_range(wa)) begin
         rf[wa[AW-1:0]] <= wd;
      end
   end

   always_comb begin
      rd1 = rf[ra1[AW-1:0]];
      rd2 = rf[ra2[AW-1:0]];
      if (we && wa == ra1) rd1 = wd;
      if (we && wa == ra2) rd2 = wd;
      if (ra1 == 5'd0 || !in_range(ra1)) rd1 = '0;
      if (ra2 == 5'd0 || !in_range(ra2)) rd2 = '0;
   end

endmodule

// File: rtl/rv_pipe_core.sv
// Three-stage (ID, EX, WB) integer core for OP, OP-IMM and LUI.
// BYPASS selects WB->EX forwarding or interlock stalls in ID.
module rv_pipe_core
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     in,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [XLEN-1:0] alu_output_data,
   output logic            out_valid,
   output logic [4:0]      out_rd,
   output logic            illegal
);

   localparam int SW = $clog2(XLEN);

   logic            rdy_q;
   logic            id_valid;
   logic [31:0]     id_ins;
   ctl_t            ctl;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            stall;

   logic            ex_valid;
   logic            ex_use_imm;
   logic            ex_wr;
   logic            ex_ill;
   alu_op_e         ex_op;
   logic [4:0]      ex_rd;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [XLEN-1:0] ex_a;
   logic [XLEN-1:0] ex_b;
   logic [XLEN-1:0] ex_imm;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;

   logic            wb_valid;
   logic            wb_wr;
   logic            wb_ill;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   function automatic logic hit(input logic [4:0] rs,
                                input logic       v,
                                input logic       w,
                                input logic [4:0] rd);
      return v && w && rd != 5'd0 && rd == rs;
   endfunction

   assign ctl = decode(id_ins, NREG, XLEN);

   always_comb begin
      id_imm = XLEN'($signed(id_ins[31:20]));
      if (id_ins[6:0] == OPC_LUI)
         id_imm = XLEN'($signed({id_ins[31:12], 12'h000}));
   end

   rv_pipe_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (ctl.rs1),
      .rd1 (rs1_val),
      .ra2 (ctl.rs2),
      .rd2 (rs2_val),
      .we  (wb_valid && wb_wr),
      .wa  (wb_rd),
      .wd  (wb_data)
   );

   always_comb begin
      stall = 1'b0;
      if (BYPASS == 0 && id_valid)
         stall = (ctl.use_rs1 &&
                  (hit(ctl.rs1, ex_valid, ex_wr, ex_rd) ||
                   hit(ctl.rs1, wb_valid, wb_wr, wb_rd))) ||
                 (ctl.use_rs2 &&
                  (hit(ctl.rs2, ex_valid, ex_wr, ex_rd) ||
                   hit(ctl.rs2, wb_valid, wb_wr, wb_rd)));
   end

   // rdy_q keeps in_ready low for the first cycle after reset
   assign in_ready = rdy_q && !rst && !stall;

   always_comb begin
      op_a = ex_a;
      op_b = ex_use_imm ? ex_imm : ex_b;
      if (BYPASS != 0 && hit(ex_rs1, wb_valid, wb_wr, wb_rd))
         op_a = wb_data;
      if (BYPASS != 0 && !ex_use_imm && hit(ex_rs2, wb_valid, wb_wr, wb_rd))
         op_b = wb_data;
   end

   always_comb begin
      alu_res = '0;
      case (ex_op)
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_SLL:  alu_res = op_a << op_b[SW-1:0];
         ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
         ALU_SLTU: alu_res = XLEN'(op_a < op_b);
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SRL:  alu_res = op_a >> op_b[SW-1:0];
         ALU_SRA:  alu_res = $signed(op_a) >>> op_b[SW-1:0];
         ALU_OR:   alu_res = op_a | op_b;
         ALU_AND:  alu_res = op_a & op_b;
         ALU_LUI:  alu_res = op_b;
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q      <= 1'b0;
         id_valid   <= 1'b0;
         id_ins     <= '0;
         ex_valid   <= 1'b0;
         ex_use_imm <= 1'b0;
         ex_wr      <= 1'b0;
         ex_ill     <= 1'b0;
         ex_op      <= ALU_ADD;
         ex_rd      <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_a       <= '0;
         ex_b       <= '0;
         ex_imm     <= '0;
         wb_valid   <= 1'b0;
         wb_wr      <= 1'b0;
         wb_ill     <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (!stall) begin
            id_valid <= in_valid && in_ready;
            id_ins   <= in;
         end
         ex_valid   <= id_valid && !stall;
         ex_use_imm <= ctl.use_imm;
         ex_wr      <= ctl.wr_en;
         ex_ill     <= ctl.illegal;
         ex_op      <= ctl.op;
         ex_rd      <= ctl.rd;
         ex_rs1     <= ctl.rs1;
         ex_rs2     <= ctl.rs2;
         ex_a       <= rs1_val;
         ex_b       <= rs2_val;
         ex_imm     <= id_imm;
         wb_valid   <= ex_valid;
         wb_wr      <= ex_wr;
         wb_ill     <= ex_ill;
         wb_rd      <= ex_rd;
         wb_data    <= ex_ill ? '0 : alu_res;
      end
   end

   assign out_valid       = wb_valid && !rst;
   assign illegal         = wb_valid && wb_ill && !rst;
   assign alu_output_data = rst ? '0 : wb_data;
   assign out_rd          = rst ? '0 : wb_rd;

endmodule

// File: tb/tb_rv_pipe_core.sv
// Directed bench: u1 is the forwarding build, u0 the interlocked build.
// Retire expectations are hand-computed and queued with their due cycle.
module tb_rv_pipe_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in1, in0;
   logic        v1, v0;
   logic        rdy1, rdy0;
   logic [31:0] dat1, dat0;
   logic        ov1, ov0;
   logic [4:0]  rd1, rd0;
   logic        ill1, ill0;

   int nvec = 0;
   int nbad = 0;
   int ncyc = 0;
   bit rdy_on = 1'b0;

   typedef struct {
      int          due;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        ill;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   rv_pipe_core #(.XLEN(32), .NREG(32), .BYPASS(1)) u1 (
      .clk             (clk),
      .rst             (rst),
      .in              (in1),
      .in_valid        (v1),
      .in_ready        (rdy1),
      .alu_output_data (dat1),
      .out_valid       (ov1),
      .out_rd          (rd1),
      .illegal         (ill1)
   );

   rv_pipe_core #(.XLEN(32), .NREG(32), .BYPASS(0)) u0 (
      .clk             (clk),
      .rst             (rst),
      .in              (in0),
      .in_valid        (v0),
      .in_ready        (rdy0),
      .alu_output_data (dat0),
      .out_valid       (ov0),
      .out_rd          (rd0),
      .illegal         (ill0)
   );

   function automatic logic [31:0] r_op(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] i_op(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] lui(input logic [4:0] rd,
      input logic [19:0] imm);
      return {imm, rd, 7'h37};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      ncyc++;
      if (rdy_on) chk("rdy1", 32'(rdy1), 32'd1);
      if (q.size() != 0 && q[0].due == ncyc) begin
         chk($sformatf("ov1@%0d", ncyc), 32'(ov1), 32'd1);
         chk($sformatf("rd1@%0d", ncyc), 32'(rd1), 32'(q[0].rd));
         chk($sformatf("ill1@%0d", ncyc), 32'(ill1), 32'(q[0].ill));
         if (!q[0].ill)
            chk($sformatf("dat1@%0d", ncyc), dat1, q[0].data);
         void'(q.pop_front());
      end else begin
         chk($sformatf("idle_ov1@%0d", ncyc), 32'(ov1), 32'd0);
         chk($sformatf("idle_ill1@%0d", ncyc), 32'(ill1), 32'd0);
      end
   endtask

   task automatic issue(input logic [31:0] ins, input logic [4:0] rd,
                        input logic [31:0] data, input logic ill);
      in1 = ins;
      v1  = 1'b1;
      q.push_back('{due: ncyc + 3, rd: rd, data: data, ill: ill});
      tick();
      v1 = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      v1  = 1'b0;
      v0  = 1'b0;
      in1 = '0;
      in0 = '0;

      // reset in progress
      tick();
      chk("rst_rdy1", 32'(rdy1), 32'd0);
      chk("rst_rdy0", 32'(rdy0), 32'd0);
      chk("rst_dat1", dat1, 32'd0);
      chk("rst_rd1", 32'(rd1), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rdy1", 32'(rdy1), 32'd0);
      chk("post_rdy0", 32'(rdy0), 32'd0);
      chk("post_ov1", 32'(ov1), 32'd0);
      rdy_on = 1'b1;
      tick();
      chk("up_rdy0", 32'(rdy0), 32'd1);

      // single ADDI, three-edge latency
      issue(i_op(12'd5, 5'd0, 3'd0, 5'd1), 5'd1, 32'd5, 1'b0);
      repeat (3) tick();

      // back-to-back dependency through WB forwarding
      issue(i_op(12'd7, 5'd0, 3'd0, 5'd1), 5'd1, 32'd7, 1'b0);
      issue(r_op(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 5'd2, 32'd14, 1'b0);
      repeat (3) tick();

      // sign/shift boundaries around 0x80000000
      issue(lui(5'd1, 20'h80000), 5'd1, 32'h8000_0000, 1'b0);
      issue(i_op(12'h404, 5'd1, 3'd5, 5'd4), 5'd4, 32'hF800_0000, 1'b0);
      issue(r_op(7'h00, 5'd1, 5'd0, 3'd3, 5'd5), 5'd5, 32'd1, 1'b0);
      issue(lui(5'd6, 20'hABCDE), 5'd6, 32'hABCD_E000, 1'b0);
      issue(r_op(7'h00, 5'd0, 5'd1, 3'd2, 5'd9), 5'd9, 32'd1, 1'b0);
      issue(i_op(12'hFFF, 5'd1, 3'd4, 5'd10), 5'd10, 32'h7FFF_FFFF, 1'b0);
      issue(i_op(12'h004, 5'd1, 3'd5, 5'd11), 5'd11, 32'h0800_0000, 1'b0);
      issue(r_op(7'h20, 5'd4, 5'd0, 3'd0, 5'd12), 5'd12, 32'h0800_0000, 1'b0);
      issue(r_op(7'h00, 5'd5, 5'd4, 3'd1, 5'd13), 5'd13, 32'hF000_0000, 1'b0);
      issue(i_op(12'h0F0, 5'd4, 3'd7, 5'd14), 5'd14, 32'd0, 1'b0);
      issue(i_op(12'h800, 5'd0, 3'd6, 5'd15), 5'd15, 32'hFFFF_F800, 1'b0);
      issue(i_op(12'd33, 5'd0, 3'd0, 5'd16), 5'd16, 32'd33, 1'b0);
      issue(r_op(7'h00, 5'd16, 5'd5, 3'd1, 5'd17), 5'd17, 32'd2, 1'b0);
      issue(r_op(7'h20, 5'd16, 5'd4, 3'd5, 5'd18), 5'd18, 32'hFC00_0000, 1'b0);
      repeat (3) tick();

      // x0 writes and an illegal opcode
      issue(i_op(12'd9, 5'd0, 3'd0, 5'd0), 5'd0, 32'd9, 1'b0);
      issue(r_op(7'h00, 5'd0, 5'd0, 3'd0, 5'd3), 5'd3, 32'd0, 1'b0);
      issue(32'h0000_00FF, 5'd1, 32'd0, 1'b1);
      issue(r_op(7'h00, 5'd0, 5'd1, 3'd0, 5'd8), 5'd8, 32'h8000_0000, 1'b0);
      repeat (3) tick();

      // reset with ID, EX and WB all occupied
      issue(i_op(12'd1, 5'd0, 3'd0, 5'd1), 5'd1, 32'd1, 1'b0);
      issue(i_op(12'd2, 5'd0, 3'd0, 5'd2), 5'd2, 32'd2, 1'b0);
      in1 = i_op(12'd3, 5'd0, 3'd0, 5'd7);
      v1  = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b1;
      v1     = 1'b0;
      rdy_on = 1'b0;
      q.delete();
      tick();
      chk("inrst_rdy1", 32'(rdy1), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst2_rdy1", 32'(rdy1), 32'd0);
      chk("rst2_ov1", 32'(ov1), 32'd0);
      chk("rst2_dat1", dat1, 32'd0);
      chk("rst2_rd1", 32'(rd1), 32'd0);
      rdy_on = 1'b1;
      tick();
      issue(r_op(7'h00, 5'd2, 5'd1, 3'd0, 5'd7), 5'd7, 32'd0, 1'b0);
      repeat (3) tick();

      // interlocked build: same dependent pair
      in0 = i_op(12'd7, 5'd0, 3'd0, 5'd1);
      v0  = 1'b1;
      chk("s0_rdy0", 32'(rdy0), 32'd1);
      chk("s0_ov0", 32'(ov0), 32'd0);
      tick();
      chk("s1_rdy0", 32'(rdy0), 32'd1);
      chk("s1_ov0", 32'(ov0), 32'd0);
      in0 = r_op(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
      tick();
      v0 = 1'b0;
      chk("s2_rdy0", 32'(rdy0), 32'd0);
      chk("s2_ov0", 32'(ov0), 32'd0);
      tick();
      chk("s3_rdy0", 32'(rdy0), 32'd0);
      chk("s3_ov0", 32'(ov0), 32'd1);
      chk("s3_rd0", 32'(rd0), 32'd1);
      chk("s3_dat0", dat0, 32'd7);
      tick();
      chk("s4_rdy0", 32'(rdy0), 32'd1);
      chk("s4_ov0", 32'(ov0), 32'd0);
      tick();
      chk("s5_rdy0", 32'(rdy0), 32'd1);
      chk("s5_ov0", 32'(ov0), 32'd0);
      tick();
      chk("s6_ov0", 32'(ov0), 32'd1);
      chk("s6_rd0", 32'(rd0), 32'd2);
      chk("s6_dat0", dat0, 32'd14);
      chk("s6_ill0", 32'(ill0), 32'd0);
      tick();
      chk("s7_ov0", 32'(ov0), 32'd0);

      chk("drain", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/rv_pipe_core.md
RV_PIPE_CORE -- requirements
Module: rv_pipe_core

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL provide parameter NREG, default 32, architectural register count (16 = RV-E subset, 32 = full).
REQ-003 SHALL provide parameter BYPASS, default 1: 1 = EX forwarding from WB; 0 = no forwarding, hazards resolved by stall.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in  input  32  instruction word.
REQ-008 in_valid  input  1  in carries an instruction this cycle.
REQ-009 in_ready  output  1  core accepts in this cycle; transfer = in_valid & in_ready.
REQ-010 alu_output_data  output  XLEN  WB-stage result.
REQ-011 out_valid  output  1  alu_output_data/out_rd describe a retiring instruction.
REQ-012 out_rd  output  5  destination register of retiring instruction.
REQ-013 illegal  output  1  one-cycle pulse: retiring slot held an unsupported instruction.

Function
REQ-014 Pipeline SHALL be three registered stages (ID, EX, WB), each with a valid bit; latency from accepted transfer at edge N to out_valid high after edge N+3, throughput one per cycle absent stalls.
REQ-015 Supported: OP (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND), OP-IMM (ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI), LUI; other opcodes, or rd/rs >= NREG, SHALL retire with illegal=1, out_valid=1, no register write.
REQ-016 Immediates SHALL be sign-extended to XLEN; LUI result = imm[31:12]<<12 sign-extended.
REQ-017 Shift amount SHALL use low log2(XLEN) bits of rs2/imm; SRA/SRAI arithmetic.
REQ-018 x0 SHALL read as zero; writes to x0 suppressed, though out_valid still reports them with the ALU result.
REQ-019 Register write SHALL occur at the edge ending the WB cycle; a same-cycle ID read of that address SHALL return the new value (write-through) when BYPASS=1.
REQ-020 BYPASS=1: EX operand rs1/rs2 SHALL take WB result when WB valid, writes, rd!=0, rd==rs; in_ready = 1 always outside reset.
REQ-021 BYPASS=0: ID SHALL stall while a used source (rs1; rs2 for OP only) matches a valid writing EX or WB rd!=0; during stall ID holds, EX receives a bubble, in_ready=0.
REQ-022 Bubbles (in_valid=0 or stall) SHALL never write registers or assert out_valid.
REQ-023 in_ready SHALL be a function of pipeline state only, not of in_valid.

Reset
REQ-024 rst SHALL clear all stage valid bits and all NREG registers to 0 at the next edge, regardless of in-flight instructions.
REQ-025 During and one cycle after rst: out_valid=0, illegal=0, alu_output_data=0, out_rd=0, in_ready=0; in_ready rises the cycle after rst deasserts.

Structure
REQ-026 Package rv_pipe_pkg SHALL hold opcode constants, the ALU-operation enum, and the decoded-control struct.
REQ-027 Register file SHALL be sub-module rv_pipe_regfile (parameters XLEN, NREG; 2 read, 1 write, write-through, sync reset).
REQ-028 Forward/stall logic SHALL be combinational inside rv_pipe_core; no latches.

Verification
REQ-029 Reset, ADDI x1,x0,5 at edge N -> out_valid after N+3, out_rd=1, data=5, illegal=0.
REQ-030 BYPASS=1, back-to-back ADDI x1,x0,7; ADD x2,x1,x1 -> in_ready constantly 1, second retire data=14 one cycle after first.
REQ-031 BYPASS=0, same pair -> in_ready low exactly 2 cycles, x2 retires data=14, no bubble retires.
REQ-032 x1=0x80000000 (XLEN=32): SRAI x4,x1,4 -> 0xF8000000; SLTU x5,x0,x1 -> 1; LUI x6,0xABCDE -> 0xABCDE000.
REQ-033 ADDI x0,x0,9 then ADD x3,x0,x0 -> first retires data=9 rd=0, second data=0; opcode 0x7F -> illegal pulse, no write.
REQ-034 rst asserted with 3 instructions in flight -> no out_valid afterward, subsequent ADD x7,x1,x2 retires 0.
